// File: rtl/cpu_bus_pkg.sv
// Shared types for the multi-cycle bus sequencer: FSM state encoding and
// ContralBus bit positions.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DACC  = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  localparam int CB_MEMWRITE = 3;
  localparam int CB_HALF     = 2;
  localparam int CB_BYTE     = 1;
  localparam int CB_EXT      = 0;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts cycles spent waiting for bus_ack; expired flags the last allowed cycle.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module bus_wait_timer
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_,
  input  logic init,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_ or negedge init) begin
    if (!init) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_seq.sv
// Multi-cycle FETCH/EXEC/DACC/WB sequencer for the shared MIPS memory bus.
// Define BUS_TIMEOUT_EN to abort a bus access that waits too long for bus_ack.
module mem_bus_seq
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk_,
  input  logic              init,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] DataBusIn,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] AddressBus,
  output logic [DATA_W-1:0] DataBusOut,
  output logic [CTRL_W-1:0] ContralBus,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] load_data,
  output logic              step,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              in_bus;
  logic              expired;
  logic              abort;

  assign in_bus = (state_q == ST_FETCH) || (state_q == ST_DACC);
  assign abort  = in_bus && !bus_ack && expired;

`ifdef BUS_TIMEOUT_EN
  // Counter sits at zero outside bus states, so every FETCH/DACC starts fresh.
  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_    (clk_),
    .init    (init),
    .clr     (!in_bus),
    .en      (in_bus && !bus_ack),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign expired        = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk_ or negedge init) begin
    if (!init) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run && !err_q) state_d = ST_FETCH;
      ST_FETCH: if (bus_ack) state_d = ST_EXEC; else if (abort) state_d = ST_IDLE;
      ST_EXEC:  state_d = (mem_write || mem_read) ? ST_DACC : ST_WB;
      ST_DACC:  if (bus_ack) state_d = ST_WB; else if (abort) state_d = ST_IDLE;
      ST_WB:    state_d = run ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Data-access parameters are frozen at EXEC exit so the bus stays stable
  // even if decode outputs move while waiting for ack.
  always_comb begin
    instr_d   = instr_q;
    load_d    = load_q;
    wdata_d   = wdata_q;
    daddr_d   = daddr_q;
    ctrl_d    = ctrl_q;
    we_d      = we_q;
    retired_d = retired_q;
    err_d     = err_q | abort;
    case (state_q)
      ST_FETCH: if (bus_ack) instr_d = DataBusIn;
      ST_EXEC: begin
        daddr_d = alu_out;
        ctrl_d  = ctrl_in;
        wdata_d = store_data;
        we_d    = mem_write;
      end
      ST_DACC:  if (bus_ack && !we_q) load_d = DataBusIn;
      ST_WB:    retired_d = retired_q + CNT_W'(1);
      default:  ;
    endcase
  end

  always_ff @(posedge clk_ or negedge init) begin
    if (!init) begin
      instr_q   <= '0;
      load_q    <= '0;
      wdata_q   <= '0;
      daddr_q   <= '0;
      ctrl_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      instr_q   <= instr_d;
      load_q    <= load_d;
      wdata_q   <= wdata_d;
      daddr_q   <= daddr_d;
      ctrl_q    <= ctrl_d;
      we_q      <= we_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  // pc is driven straight through in FETCH: the PC register advances on the
  // same edge that leaves WB, so capturing it earlier would fetch stale code.
  always_comb begin
    AddressBus = '0;
    DataBusOut = '0;
    ContralBus = '0;
    bus_we     = 1'b0;
    bus_req    = in_bus;
    step       = (state_q == ST_WB);
    busy       = (state_q != ST_IDLE);
    if (state_q == ST_FETCH) begin
      AddressBus = pc;
    end else if (state_q == ST_DACC) begin
      AddressBus = daddr_q;
      DataBusOut = wdata_q;
      ContralBus = ctrl_q;
      bus_we     = we_q;
    end
  end

  assign instr     = instr_q;
  assign load_data = load_q;
  assign err       = err_q;
  assign retired   = retired_q;

endmodule
